// File: rtl/tuser_out_fsm.sv
// Egress tuple re-attach: buffers SDNet output tuples in a small FIFO and releases
// each outgoing AXI-Stream packet only once its tuple is at the FIFO head, driving it as TUSER.
module tuser_out_fsm #(
  parameter int TUPLE_DEPTH = 4,
  parameter int TUPLE_W     = 128
) (
  input  logic               tout_aclk,
  input  logic               tout_arst,
  input  logic               tout_avalid,
  output logic               tout_aready,
  input  logic [255:0]       tout_adata,
  input  logic [31:0]        tout_akeep,
  input  logic               tout_atlast,
  input  logic               tout_valid,
  input  logic [TUPLE_W-1:0] tout_data,
  output logic               tout_bvalid,
  input  logic               tout_bready,
  output logic [255:0]       tout_bdata,
  output logic [31:0]        tout_bkeep,
  output logic               tout_btlast,
  output logic [TUPLE_W-1:0] tout_btuser,
  output logic [0:2]         dbg_state,
  output logic [7:0]         dbg_drops,
  output logic [15:0]        dbg_pkts
);

  localparam int AW = $clog2(TUPLE_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [2:0] {
    IDLE       = 3'b000,
    WAIT_TUPLE = 3'b001,
    BODY       = 3'b010
  } state_t;

  state_t              state_r;
  logic [TUPLE_W-1:0]  fifo_mem_r [TUPLE_DEPTH];
  logic [PW-1:0]       wr_ptr_r;
  logic [PW-1:0]       rd_ptr_r;
  logic [7:0]          drops_r;
  logic [15:0]         pkts_r;

  logic                empty_s;
  logic                full_s;
  logic                pass_s;
  logic                hs_s;
  logic                pop_s;
  logic                push_s;
  logic                drop_s;
  logic [TUPLE_W-1:0]  head_s;

  // FIFO status, pass gating and handshake-derived push/pop/drop strobes.
  always_comb begin
    empty_s = 1'b0;
    full_s  = 1'b0;
    pass_s  = 1'b0;
    hs_s    = 1'b0;
    pop_s   = 1'b0;
    push_s  = 1'b0;
    drop_s  = 1'b0;
    head_s  = {TUPLE_W{1'b0}};
    empty_s = (wr_ptr_r == rd_ptr_r);
    full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
              (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    pass_s  = (state_r == BODY) || !empty_s;
    hs_s    = tout_avalid && tout_bready && pass_s;
    pop_s   = hs_s && tout_atlast;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    push_s  = tout_valid && (!full_s || pop_s);
    drop_s  = tout_valid && full_s && !pop_s;
    if (empty_s) begin
      head_s = {TUPLE_W{1'b0}};
    end else begin
      head_s = fifo_mem_r[rd_ptr_r[AW-1:0]];
    end
  end

  // Tuple storage; contents are qualified by the pointers so no reset is needed.
  always_ff @(posedge tout_aclk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r[AW-1:0]] <= tout_data;
    end
  end

  // Pointers, debug counters and packet FSM.
  always_ff @(posedge tout_aclk or negedge tout_arst) begin
    if (!tout_arst) begin
      state_r  <= IDLE;
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      drops_r  <= 8'd0;
      pkts_r   <= 16'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
        pkts_r   <= pkts_r + 16'd1;
      end
      if (drop_s && (drops_r != 8'hFF)) begin
        drops_r <= drops_r + 8'd1;
      end
      case (state_r)
        IDLE: begin
          if (hs_s && !tout_atlast) begin
            state_r <= BODY;
          end else if (tout_avalid && empty_s && !push_s) begin
            state_r <= WAIT_TUPLE;
          end else begin
            state_r <= IDLE;
          end
        end
        // Leaves on the push edge so the beat can go out the following cycle.
        WAIT_TUPLE: begin
          if (hs_s && !tout_atlast) begin
            state_r <= BODY;
          end else if (!empty_s || push_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= WAIT_TUPLE;
          end
        end
        BODY: begin
          if (pop_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= BODY;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign tout_bvalid = tout_avalid && pass_s;
  assign tout_aready = tout_bready && pass_s;
  assign tout_bdata  = tout_adata;
  assign tout_bkeep  = tout_akeep;
  assign tout_btlast = tout_atlast;
  assign tout_btuser = head_s;
  assign dbg_state   = state_r;
  assign dbg_drops   = drops_r;
  assign dbg_pkts    = pkts_r;

endmodule

// File: doc/tuser_out_fsm.md
# tuser_out_fsm

Egress-side counterpart of the tuser ingress FSM: takes the 256-bit AXI-Stream packet leaving the SDNet pipeline together with the 128-bit output tuple SDNet produces for it, and re-attaches the tuple as TUSER on the outgoing stream toward the NetFPGA output queues. Tuples carry valid only, with no backpressure, so they are buffered in a small FIFO. Each packet is released only once its tuple is at the FIFO head, preserving packet/tuple pairing in order.

## Interface
Parameters:
- TUPLE_DEPTH, 4: tuple FIFO entries (power of 2, ≥2)
- TUPLE_W, 128: tuple / TUSER width

Ports:
- tout_aclk  in  1  clock; all logic rising-edge
- tout_arst  in  1  reset, asynchronous, active-low (0 = reset)
- tout_avalid  in  1  SDNet packet stream valid
- tout_aready  out  1  SDNet packet stream ready
- tout_adata  in  256  packet data
- tout_akeep  in  32  byte enables
- tout_atlast  in  1  last beat
- tout_valid  in  1  tuple valid (single-cycle pulse per packet)
- tout_data  in  TUPLE_W  tuple contents
- tout_bvalid  out  1  output stream valid
- tout_bready  in  1  output stream ready
- tout_bdata  out  256  = tout_adata
- tout_bkeep  out  32  = tout_akeep
- tout_btlast  out  1  = tout_atlast
- tout_btuser  out  TUPLE_W  tuple at FIFO head, constant over the packet
- dbg_state  out  [0:2]  FSM state encoding
- dbg_drops  out  8  tuples dropped on full FIFO, saturating at 255
- dbg_pkts  out  16  packets completed, wrapping

## Operation
- Tuple FIFO: push when tout_valid=1 and not full. Pop on the output handshake (bvalid & bready) of a beat with tlast=1.
- Full with tout_valid=1 and no pop that cycle: tuple discarded, dbg_drops increments.
- Push and pop in the same cycle while full: pop frees a slot, push accepted, count unchanged.
- Data beats pass through combinationally. No data storage in this block.
- Define pass = (state==BODY) or (FIFO not empty).
- tout_bvalid = tout_avalid & pass. tout_aready = tout_bready & pass.
- tout_btuser = FIFO head entry. It is 0 while the FIFO is empty.
- FSM states:
  - IDLE (000): no packet in progress.
    - avalid=1, FIFO empty → WAIT_TUPLE.
    - Handshake with tlast=0 → BODY.
    - Handshake with tlast=1 (single-beat packet) → stay IDLE, pop.
  - WAIT_TUPLE (001): bvalid=0, aready=0.
    - When the FIFO becomes non-empty → IDLE, and the packet is released from the following cycle.
  - BODY (010): beats pass; the head stays unpopped.
    - Handshake with tlast=1 → IDLE, pop, dbg_pkts+1.
    - Single-beat packets in IDLE also increment dbg_pkts.
- Tuple arriving while in BODY: enqueued behind the head; it does not affect the current packet.
- Reset asserted mid-packet: FIFO emptied, FSM → IDLE, counters cleared. Downstream sees a truncated packet; recovery is the system's responsibility.

## Timing
- Reset values (asynchronous, immediate on tout_arst=0):
  - tout_aready=0, tout_bvalid=0, tout_btuser=0.
  - dbg_state=000, dbg_drops=0, dbg_pkts=0.
  - FIFO empty; read and write pointers 0.
- Data outputs track their inputs combinationally at all times.
- Tuple pushed at edge N is visible on tout_btuser, and enables pass, from cycle N+1. Minimum tuple-to-first-beat latency is 1 cycle.
- Packet beat with its tuple already at the head: 0-cycle latency a→b. Throughput is 1 beat/cycle.
- Back-to-back packets: the pop at the tlast edge exposes the next head in the next cycle. No bubble if the next tuple is already queued.
- AXIS rules on the b side:
  - bvalid is not deasserted without a handshake once the packet has started (BODY holds pass=1).
  - bdata, bkeep, btlast and btuser are stable while bvalid=1 and bready=0, provided the source holds its inputs.

## Test plan
- Tuple 0x…AAAA pulsed, then a 3-beat packet 2 cycles later, bready=1 → 3 beats out, btuser=0x…AAAA on every beat, dbg_pkts=1, FIFO empty afterwards.
- Packet presented with no tuple for 5 cycles → dbg_state=001, bvalid=0, aready=0. Tuple 0x55 arrives → first beat out the next cycle, btuser=0x55.
- Tuples T1,T2,T3 queued, then three 1-beat packets back-to-back → btuser sequence T1,T2,T3 on consecutive cycles, dbg_pkts=3.
- 6 tuples pushed with no packets (TUPLE_DEPTH=4) → dbg_drops=2. Four packets then carry tuples 1–4 in order.
- bready toggled 1,0,1,0 during a 4-beat packet → no beat lost or duplicated, and aready mirrors bready. A tuple pushed mid-packet does not change btuser until after tlast.
- tout_arst=0 asserted in BODY → outputs go to reset values immediately, FIFO empty. After release, a new tuple+packet pair passes correctly.
